rf_op_sequencer: RTL
====================

// Module: rf_op_sequencer
// PURPOSE
//  Multi-cycle FSM that sequences the in-memory-compute register file (32 rows + buffer row 32) for one decoded instruction at a time.
//  Accepts op/indices over valid/ready, drives every reg_file control, handshakes data memory for LOAD/STORE, and pulses done/err.
//  Sits between the decoder and reg_file; immediate/pc/dataFromMem buses go to reg_file directly, this block only gates them.
// PARAMETERS
//  IDX_W    5   register index width (rd/rs1/rs2)
//  MEM_TMO  16  max cycles in ADDR waiting for mem_ack before abort (>=2)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      instruction present
//  in_ready   out  1      block can accept (high only in IDLE)
//  in_op      in   4      op class: 0 ADD 1 AND 2 XOR 3 OR 4 SUB 5 ADDI 6 LUI 7 AUIPC 8 LOAD 9 STORE 10 JAL 11 BRANCH, 12-15 illegal
//  in_rd      in   IDX_W  destination index
//  in_rs1     in   IDX_W  source 1 index
//  in_rs2     in   IDX_W  source 2 index
//  mem_ack    in   1      memory completed current request
//  mem_req    out  1      memory request, held until mem_ack
//  mem_we     out  1      1=store, 0=load; valid while mem_req
//  rd_index   out  IDX_W  latched rd to reg_file
//  rs1_index  out  IDX_W  latched rs1 to reg_file
//  rs2_index  out  IDX_W  latched rs2 to reg_file
//  op_fa      out  4      one-hot FA op: 0001 sum 0010 and 0100 xor 1000 or; 0000 when idle
//  rf_ctrl    out  14     reg_file enables, bit map below
//    [0]write_en [1]data2bus_en [2]op_enable [3]exp_go_up [4]exp_go_dn [5]buffer_read [6]buffer_write
//    [7]inv_en [8]imm_en [9]dataFM_en [10]carry_in [11]pc_plus_en [12]pc_imm_en [13]imm_up_en
//  done       out  1      1-cycle pulse in final cycle of a legal op
//  err        out  1      1-cycle pulse: illegal op or memory timeout
// BEHAVIOUR
//  Reset: state=IDLE, tmo counter=0; in_ready=1; every other output 0 (indices 0, op_fa 0, rf_ctrl 0).
//  States IDLE, INV, EXEC, ADDR, WB, ERR. Outputs are Moore decodes of state + latched op; never from in_* directly.
//  IDLE: on in_valid&in_ready latch op/rd/rs1/rs2. Next: SUB->INV; LOAD/STORE->ADDR; illegal->ERR; other->EXEC.
//  EXEC (1 cycle, then IDLE, done=1), per op:
//   ADD/AND/XOR/OR: op_enable, data2bus_en, op_fa per op, write_en.
//   SUB (after INV): op_enable, buffer_read, carry_in, op_fa=0001, write_en.
//   ADDI: op_enable, imm_en, op_fa=0001, write_en.   LUI: imm_up_en, write_en.
//   AUIPC: pc_imm_en, write_en.   JAL: pc_plus_en, write_en.   BRANCH: exp_go_dn, op_fa=0100, no write_en.
//  INV (SUB, 1 cycle, then EXEC): data2bus_en, inv_en, op_fa=0100, buffer_write; rs2 XOR ones -> buffer row.
//  ADDR: exp_go_up, op_enable, imm_en, op_fa=0001, mem_req=1; STORE adds data2bus_en, mem_we=1. Controls held stable.
//   mem_ack: STORE -> IDLE with done; LOAD -> WB. Counter increments each ADDR cycle without ack.
//   Counter reaching MEM_TMO-1 without ack -> ERR, mem_req drops next cycle; counter clears on leaving ADDR.
//  WB (LOAD, 1 cycle): dataFM_en, write_en, done=1, then IDLE.
//  ERR (1 cycle): err=1, rf_ctrl=0, no write, then IDLE.
//  rd==0: write_en forced 0 in every state (x0 stays zero); sequence and done timing unchanged.
//  mem_ack outside ADDR is ignored. rst in any state wins: next cycle IDLE, no write_en, no done.
//  Latency accept->done: 1-cycle ops 1, SUB 2, STORE 1+wait, LOAD 2+wait; in_ready returns cycle after done.
// TESTING
//  ADD rd=3 rs1=1 rs2=2 -> next cycle op_fa=0001, rf_ctrl[0,1,2]=1, done=1; in_ready back after 1 cycle.
//  SUB rd=4 rs1=1 rs2=2 -> INV cycle rf_ctrl[1,6,7]=1 op_fa=0100; EXEC cycle rf_ctrl[0,2,5,10]=1 op_fa=0001, done.
//  LOAD, mem_ack 3 cycles late -> mem_req/mem_we=0 held 4 cycles, controls stable, WB rf_ctrl[0,9]=1, done.
//  STORE, mem_ack never -> mem_req high exactly MEM_TMO=16 cycles, err pulse, no done, no write_en anywhere.
//  ADD rd=0 -> rf_ctrl[0]=0 throughout, done still pulses; in_op=13 -> err pulse, rf_ctrl=0.
//  rst asserted during LOAD ADDR -> next cycle IDLE, all outputs 0, late mem_ack ignored, no done.

Source files
------------

// File: rtl/rf_op_sequencer.sv
// Per-instruction control sequencer for the in-memory-compute register file.
// Moore decode of state and latched op; the only input-driven output is the STORE done on mem_ack.
module rf_op_sequencer #(
  parameter int IDX_W   = 5,
  parameter int MEM_TMO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [IDX_W-1:0] in_rd,
  input  logic [IDX_W-1:0] in_rs1,
  input  logic [IDX_W-1:0] in_rs2,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [IDX_W-1:0] rd_index,
  output logic [IDX_W-1:0] rs1_index,
  output logic [IDX_W-1:0] rs2_index,
  output logic [3:0]       op_fa,
  output logic [13:0]      rf_ctrl,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = (MEM_TMO > 2) ? $clog2(MEM_TMO) : 1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_AND   = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_ADDI  = 4'd5;
  localparam logic [3:0] OP_LUI   = 4'd6;
  localparam logic [3:0] OP_AUIPC = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_STORE = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_BR    = 4'd11;

  localparam int B_WE = 0, B_D2B = 1, B_OPEN = 2, B_UP = 3, B_DN = 4, B_BRD = 5, B_BWR = 6;
  localparam int B_INV = 7, B_IMM = 8, B_DFM = 9, B_CIN = 10, B_PCP = 11, B_PCI = 12, B_IMU = 13;

  localparam logic [3:0] FA_SUM = 4'b0001;
  localparam logic [3:0] FA_AND = 4'b0010;
  localparam logic [3:0] FA_XOR = 4'b0100;
  localparam logic [3:0] FA_OR  = 4'b1000;

  typedef enum logic [2:0] {S_IDLE, S_INV, S_EXEC, S_ADDR, S_WB, S_ERR} state_t;

  state_t           state, state_nxt;
  logic [3:0]       op_r;
  logic [IDX_W-1:0] rd_r, rs1_r, rs2_r;
  logic [CNT_W-1:0] cnt_r;
  logic [13:0]      ctrl_s;

  // State, latched instruction fields and memory-wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_r  <= 4'd0;
      rd_r  <= '0;
      rs1_r <= '0;
      rs2_r <= '0;
      cnt_r <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && in_valid) begin
        op_r  <= in_op;
        rd_r  <= in_rd;
        rs1_r <= in_rs1;
        rs2_r <= in_rs2;
      end
      if (state == S_ADDR && state_nxt == S_ADDR) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= '0;
      end
    end
  end

  // Next-state selection and per-state control decode.
  always_comb begin
    state_nxt = state;
    ctrl_s    = 14'd0;
    op_fa     = 4'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (in_op > OP_BR)                             state_nxt = S_ERR;
          else if (in_op == OP_SUB)                      state_nxt = S_INV;
          else if (in_op == OP_LOAD || in_op == OP_STORE) state_nxt = S_ADDR;
          else                                           state_nxt = S_EXEC;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_INV: begin
        // rs2 inverted into the buffer row; EXEC adds it back with carry-in
        ctrl_s[B_D2B] = 1'b1;
        ctrl_s[B_INV] = 1'b1;
        ctrl_s[B_BWR] = 1'b1;
        op_fa         = FA_XOR;
        state_nxt     = S_EXEC;
      end
      S_EXEC: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
        case (op_r)
          OP_ADD, OP_AND, OP_XOR, OP_OR: begin
            ctrl_s[B_OPEN] = 1'b1;
            ctrl_s[B_D2B]  = 1'b1;
            ctrl_s[B_WE]   = 1'b1;
            case (op_r)
              OP_AND:  op_fa = FA_AND;
              OP_XOR:  op_fa = FA_XOR;
              OP_OR:   op_fa = FA_OR;
              default: op_fa = FA_SUM;
            endcase
          end
          OP_SUB: begin
            ctrl_s[B_OPEN] = 1'b1;
            ctrl_s[B_BRD]  = 1'b1;
            ctrl_s[B_CIN]  = 1'b1;
            ctrl_s[B_WE]   = 1'b1;
            op_fa          = FA_SUM;
          end
          OP_ADDI: begin
            ctrl_s[B_OPEN] = 1'b1;
            ctrl_s[B_IMM]  = 1'b1;
            ctrl_s[B_WE]   = 1'b1;
            op_fa          = FA_SUM;
          end
          OP_LUI:   begin ctrl_s[B_IMU] = 1'b1; ctrl_s[B_WE] = 1'b1; end
          OP_AUIPC: begin ctrl_s[B_PCI] = 1'b1; ctrl_s[B_WE] = 1'b1; end
          OP_JAL:   begin ctrl_s[B_PCP] = 1'b1; ctrl_s[B_WE] = 1'b1; end
          OP_BR:    begin ctrl_s[B_DN]  = 1'b1; op_fa = FA_XOR; end
          default:  ctrl_s = 14'd0;
        endcase
      end
      S_ADDR: begin
        ctrl_s[B_UP]   = 1'b1;
        ctrl_s[B_OPEN] = 1'b1;
        ctrl_s[B_IMM]  = 1'b1;
        op_fa          = FA_SUM;
        mem_req        = 1'b1;
        if (op_r == OP_STORE) begin
          ctrl_s[B_D2B] = 1'b1;
          mem_we        = 1'b1;
        end else begin
          mem_we        = 1'b0;
        end
        // an ack in the last allowed cycle still completes the access
        if (mem_ack) begin
          if (op_r == OP_STORE) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_WB;
          end
        end else if (cnt_r == CNT_W'(MEM_TMO - 1)) begin
          state_nxt = S_ERR;
        end else begin
          state_nxt = S_ADDR;
        end
      end
      S_WB: begin
        ctrl_s[B_DFM] = 1'b1;
        ctrl_s[B_WE]  = 1'b1;
        done          = 1'b1;
        state_nxt     = S_IDLE;
      end
      S_ERR: begin
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (state == S_IDLE);
  assign rd_index  = rd_r;
  assign rs1_index = rs1_r;
  assign rs2_index = rs2_r;
  // x0 is hard-wired zero, so writes to it are suppressed without altering the sequence
  assign rf_ctrl   = {ctrl_s[13:1], ctrl_s[B_WE] & (rd_r != '0)};

endmodule
